// File: rtl/img_proc_pkg.sv
// Shared types and constants for the camera-to-window-generator front end.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the sequencer state encoding, default image geometry and edge patterns.
package img_proc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOF,
      ACTIVE,
      DONE
   } seq_state_t;

   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;
   localparam int CNT_W_DEF = 12;

   // Edge patterns are {current, previous}.
   localparam logic [1:0] EDGE_RISE = 2'b10;
   localparam logic [1:0] EDGE_FALL = 2'b01;

   function automatic logic is_edge(input logic cur, input logic prev, input logic [1:0] pat);
      return ({cur, prev} == pat);
   endfunction

endpackage

// File: rtl/frame_window_sequencer_window_pos_tracker.sv
// Tracks row/column of the window generator output and flags fully-populated windows.
// Latency: window_valid is combinational on href/clken; counters update 1 cycle later.
// Backpressure: none, follows the generator's strobes.
module window_pos_tracker
   import img_proc_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int BORDER = 2   // rows/cols of history a window needs: 2 for 3x3, 4 for 5x5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic href,
   input  logic clken,
   input  logic clear,
   output logic window_valid
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] BORDER_V = CNT_W'(BORDER);

   logic             href_d;
   logic [CNT_W-1:0] win_row;
   logic [CNT_W-1:0] win_col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         href_d  <= 1'b0;
         win_row <= '0;
         win_col <= '0;
      end else begin
         href_d <= href;
         if (!href) begin
            win_col <= '0;
         end else if (clken && (win_col != CNT_MAX)) begin
            win_col <= win_col + 1'b1;
         end
         if (clear) begin
            win_row <= '0;
         end else if (is_edge(href, href_d, EDGE_FALL) && (win_row != CNT_MAX)) begin
            win_row <= win_row + 1'b1;
         end
      end
   end

   // Uses pre-increment counts so the pixel at (BORDER, BORDER) is the first valid one.
   assign window_valid = href & clken & (win_row >= BORDER_V) & (win_col >= BORDER_V);

endmodule

// File: rtl/frame_window_sequencer.sv
// Passes exactly one camera frame per start to the 3x3 window generator; FRAME_CHECK_EN adds size checking.
// Latency: gated camera signals 1 cycle; done 1 cycle after vsync fall.
// Backpressure: none, camera stream is gated or dropped, never stalled.
module frame_window_sequencer
   import img_proc_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       cam_vsync,
   input  logic       cam_href,
   input  logic       cam_clken,
   input  logic [7:0] cam_y,
   output logic       per_frame_vsync,
   output logic       per_frame_href,
   output logic       per_frame_clken,
   output logic [7:0] per_img_y,
   input  logic       matrix_frame_href,
   input  logic       matrix_frame_clken,
   output logic       window_valid,
   output logic       busy,
   output logic       done,
   output logic       frame_err
);

   if (((2 ** CNT_W) <= IMG_W) || ((2 ** CNT_W) <= IMG_H)) begin : g_cnt_w_check
      $error("CNT_W too narrow for IMG_W/IMG_H");
   end

   seq_state_t state_q, state_d;
   logic       vsync_d;
   logic       pf_vsync_d;
   logic       rise, fall, pass;

   assign rise = is_edge(cam_vsync, vsync_d, EDGE_RISE);
   assign fall = is_edge(cam_vsync, vsync_d, EDGE_FALL);

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     if (start) state_d = WAIT_SOF;
            WAIT_SOF: if (rise)  state_d = ACTIVE;
            ACTIVE:   if (fall)  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   // The rising-edge cycle itself is passed so the downstream frame sees its vsync rise.
   assign pass = (state_q == ACTIVE) | ((state_q == WAIT_SOF) & rise & ~abort);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         vsync_d         <= 1'b0;
         pf_vsync_d      <= 1'b0;
         busy            <= 1'b0;
         per_frame_vsync <= 1'b0;
         per_frame_href  <= 1'b0;
         per_frame_clken <= 1'b0;
         per_img_y       <= '0;
      end else begin
         state_q         <= state_d;
         vsync_d         <= cam_vsync;
         pf_vsync_d      <= per_frame_vsync;
         busy            <= (state_d == WAIT_SOF) || (state_d == ACTIVE);
         per_frame_vsync <= cam_vsync & pass;
         per_frame_href  <= cam_href & pass;
         per_frame_clken <= cam_clken & pass;
         per_img_y       <= pass ? cam_y : 8'd0;
      end
   end

   assign done = (state_q == DONE);

   window_pos_tracker #(
      .CNT_W  (CNT_W),
      .BORDER (2)
   ) u_tracker (
      .clk          (clk),
      .rst_n        (rst_n),
      .href         (matrix_frame_href),
      .clken        (matrix_frame_clken),
      .clear        ((per_frame_vsync & ~pf_vsync_d) | abort),
      .window_valid (window_valid)
   );

`ifdef FRAME_CHECK_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             pf_href_d;
   logic [CNT_W-1:0] px_cnt;
   logic [CNT_W-1:0] ln_cnt;
   logic [CNT_W:0]   lines_total;
   logic             line_end;
   logic             in_frame;
   logic             start_acc;
   logic             err_q;

   assign start_acc = start & ~abort & (state_q == IDLE);
   assign line_end  = pf_href_d & ~per_frame_href;
   // A gated line can end in the DONE cycle when href and vsync drop together.
   assign in_frame    = (state_q == ACTIVE) || (state_q == DONE);
   assign lines_total = {1'b0, ln_cnt} + (CNT_W + 1)'(line_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pf_href_d <= 1'b0;
         px_cnt    <= '0;
         ln_cnt    <= '0;
         err_q     <= 1'b0;
      end else begin
         pf_href_d <= per_frame_href;
         if (!per_frame_href) begin
            px_cnt <= '0;
         end else if (per_frame_clken && (px_cnt != CNT_MAX)) begin
            px_cnt <= px_cnt + 1'b1;
         end
         if (start_acc || (per_frame_vsync && !pf_vsync_d)) begin
            ln_cnt <= '0;
         end else if (line_end && (ln_cnt != CNT_MAX)) begin
            ln_cnt <= ln_cnt + 1'b1;
         end
         if (start_acc) begin
            err_q <= 1'b0;
         end else if (in_frame && ((line_end && (px_cnt != CNT_W'(IMG_W))) ||
                                   ((state_q == DONE) && (lines_total != (CNT_W + 1)'(IMG_H))))) begin
            err_q <= 1'b1;
         end
      end
   end

   assign frame_err = err_q;
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_window_sequencer.sv
// Randomized self-checking bench for frame_window_sequencer on an 8x4 image.
// A 2-cycle delay line stands in for the window generator's returned timing.
module tb_frame_window_sequencer;

   localparam int W = 8;
   localparam int H = 4;
`ifdef FRAME_CHECK_EN
   localparam logic FE_EXP = 1'b1;
`else
   localparam logic FE_EXP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       cam_vsync = 1'b0;
   logic       cam_href = 1'b0;
   logic       cam_clken = 1'b0;
   logic [7:0] cam_y = 8'd0;
   logic       per_frame_vsync, per_frame_href, per_frame_clken;
   logic [7:0] per_img_y;
   logic       matrix_frame_href, matrix_frame_clken;
   logic       window_valid, busy, done, frame_err;
   logic [1:0] mh_sr = 2'b00;
   logic [1:0] mc_sr = 2'b00;

   int n_assert = 0;
   int n_fail = 0;

   // Written only by the monitor.
   int         cyc = 0;
   logic [7:0] obs_y[$];
   bit         wv_flags[$];
   int         wv_cnt = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         pf_rise_cyc = 0;
   logic       pf_vs_prev = 1'b0;
   logic       fe_at_done = 1'b0;

   // Written only by the stimulus process.
   logic [7:0] exp_y[$];
   int         fr_rise_cyc = 0;
   int         fr_fall_cyc = 0;

   frame_window_sequencer #(.IMG_W(W), .IMG_H(H), .CNT_W(12)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .abort              (abort),
      .cam_vsync          (cam_vsync),
      .cam_href           (cam_href),
      .cam_clken          (cam_clken),
      .cam_y              (cam_y),
      .per_frame_vsync    (per_frame_vsync),
      .per_frame_href     (per_frame_href),
      .per_frame_clken    (per_frame_clken),
      .per_img_y          (per_img_y),
      .matrix_frame_href  (matrix_frame_href),
      .matrix_frame_clken (matrix_frame_clken),
      .window_valid       (window_valid),
      .busy               (busy),
      .done               (done),
      .frame_err          (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mh_sr <= {mh_sr[0], per_frame_href};
      mc_sr <= {mc_sr[0], per_frame_clken};
   end
   assign matrix_frame_href  = mh_sr[1];
   assign matrix_frame_clken = mc_sr[1];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (per_frame_clken) obs_y.push_back(per_img_y);
      if (per_frame_vsync && !pf_vs_prev) pf_rise_cyc = cyc;
      pf_vs_prev = per_frame_vsync;
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         fe_at_done = frame_err;
      end
      if (matrix_frame_href && matrix_frame_clken) wv_flags.push_back(window_valid);
      if (window_valid) wv_cnt = wv_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #2;
      start = 1'b0;
      abort = 1'b0;
      cam_clken = 1'b0;
   endtask

   // Pixels of the passed frame that differ from what the camera sent.
   function automatic int pix_mismatch(input int ob);
      int bad = 0;
      for (int i = 0; i < exp_y.size(); i++)
         if (obs_y[ob + i] !== exp_y[i]) bad++;
      return bad;
   endfunction

   // Windows whose valid flag disagrees with "row >= 2 and col >= 2" of a WxH raster.
   function automatic int win_mismatch(input int wb);
      int bad = 0;
      for (int k = 0; k < W * H; k++)
         if (wv_flags[wb + k] !== ((k / W >= 2) && (k % W >= 2))) bad++;
      return bad;
   endfunction

   // One camera frame; start/abort fire on the given frame pixel index (-1 = never).
   task automatic cam_frame(input int h, input int short_line, input int start_at,
                            input int abort_at, input bit exp_pass);
      int pidx = 0;
      int w;
      bit hit;
      cam_vsync = 1'b1;
      fr_rise_cyc = cyc;
      step();
      step();
      for (int l = 0; l < h; l++) begin
         w = (l == short_line) ? W - 1 : W;
         for (int p = 0; p < w; p++) begin
            cam_href = 1'b1;
            if ($urandom_range(0, 3) == 0) step();
            cam_clken = 1'b1;
            cam_y = 8'($urandom);
            hit = (pidx == abort_at);
            if (pidx == start_at) start = 1'b1;
            if (hit) abort = 1'b1;
            if (exp_pass && (abort_at < 0 || pidx <= abort_at)) exp_y.push_back(cam_y);
            pidx++;
            step();
            if (hit) begin
               n_assert++;
               if (busy !== 1'b0) begin
                  n_fail++;
                  $display("FAIL abort_busy: got %b want 0", busy);
               end
               cam_clken = 1'b1;
               cam_y = 8'hA5;
               pidx++;
               step();
               n_assert++;
               if ({per_frame_vsync, per_frame_href, per_frame_clken, per_img_y} !== 11'd0) begin
                  n_fail++;
                  $display("FAIL abort_gate: got %b%b%b y=%0h want all 0",
                           per_frame_vsync, per_frame_href, per_frame_clken, per_img_y);
               end
            end
         end
         cam_href = 1'b0;
         cam_y = 8'($urandom);
         repeat (3) step();
      end
      cam_vsync = 1'b0;
      fr_fall_cyc = cyc;
      repeat (4) step();
   endtask

   task automatic test_reset();
      start = 1'b1;
      step();
      n_assert++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
      cam_vsync = 1'b1;
      step();
      cam_href = 1'b1;
      cam_clken = 1'b1;
      cam_y = 8'h5A;
      step();
      n_assert++;
      if (per_frame_clken !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre_pixel: got %b want 1", per_frame_clken);
      end
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cam_href = 1'($urandom);
         cam_clken = 1'($urandom);
         cam_y = 8'($urandom);
         #1;
         n_assert++;
         if ({per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
              window_valid, busy, done, frame_err} !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_outputs: got %b want 0", {per_frame_vsync, per_frame_href,
                     per_frame_clken, per_img_y, window_valid, busy, done, frame_err});
         end
         step();
      end
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cam_vsync = (i >= 2 && i < 8);
         cam_href = 1'($urandom);
         cam_clken = 1'($urandom);
         cam_y = 8'($urandom);
         step();
         n_assert++;
         if ({per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
              window_valid, busy, done, frame_err} !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_idle_gate: cycle %0d got %b want 0", i, {per_frame_vsync,
                     per_frame_href, per_frame_clken, per_img_y, window_valid, busy, done, frame_err});
         end
      end
      cam_vsync = 1'b0;
      cam_href = 1'b0;
      cam_y = 8'd0;
      repeat (3) step();
   endtask

   task automatic test_arm_mid_frame();
      int ob, dc;
      exp_y.delete();
      ob = obs_y.size();
      dc = done_cnt;
      cam_vsync = 1'b1;
      step();
      step();
      cam_frame(H, -1, 5, -1, 1'b0);
      n_assert++;
      if (obs_y.size() - ob !== 0) begin
         n_fail++;
         $display("FAIL arm_in_progress: got %0d pixels want 0", obs_y.size() - ob);
      end
      n_assert++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL arm_waiting: busy %b want 1", busy); end
      ob = obs_y.size();
      cam_frame(H, -1, -1, -1, 1'b1);
      n_assert++;
      if (obs_y.size() - ob !== W * H) begin
         n_fail++;
         $display("FAIL pass_count: got %0d want %0d", obs_y.size() - ob, W * H);
      end else begin
         n_assert++;
         if (pix_mismatch(ob) !== 0) begin
            n_fail++;
            $display("FAIL pass_data: %0d bad pixels want 0", pix_mismatch(ob));
         end
      end
      n_assert++;
      if (pf_rise_cyc !== fr_rise_cyc + 2) begin
         n_fail++;
         $display("FAIL vsync_latency: rise at %0d want %0d", pf_rise_cyc, fr_rise_cyc + 2);
      end
      n_assert++;
      if (done_cnt - dc !== 1 || done_cyc !== fr_fall_cyc + 2) begin
         n_fail++;
         $display("FAIL done_pulse: count %0d at %0d want 1 at %0d",
                  done_cnt - dc, done_cyc, fr_fall_cyc + 2);
      end
      n_assert++;
      if ({busy, frame_err} !== 2'b00) begin
         n_fail++;
         $display("FAIL arm_end_state: busy/err %b want 00", {busy, frame_err});
      end
   endtask

   task automatic test_window();
      int wb, wc;
      exp_y.delete();
      start = 1'b1;
      step();
      wb = wv_flags.size();
      wc = wv_cnt;
      cam_frame(H, -1, -1, -1, 1'b1);
      n_assert++;
      if (wv_cnt - wc !== (W - 2) * (H - 2)) begin
         n_fail++;
         $display("FAIL win_count: got %0d want %0d", wv_cnt - wc, (W - 2) * (H - 2));
      end
      n_assert++;
      if (wv_flags.size() - wb !== W * H) begin
         n_fail++;
         $display("FAIL win_pixels: got %0d want %0d", wv_flags.size() - wb, W * H);
      end else begin
         n_assert++;
         if (win_mismatch(wb) !== 0) begin
            n_fail++;
            $display("FAIL win_position: %0d misplaced want 0", win_mismatch(wb));
         end
      end
   endtask

   task automatic test_abort();
      int ob, dc;
      exp_y.delete();
      start = 1'b1;
      step();
      ob = obs_y.size();
      dc = done_cnt;
      cam_frame(H, -1, -1, 9, 1'b1);
      n_assert++;
      if (obs_y.size() - ob !== 10) begin
         n_fail++;
         $display("FAIL abort_count: got %0d want 10", obs_y.size() - ob);
      end
      n_assert++;
      if (done_cnt - dc !== 0) begin
         n_fail++;
         $display("FAIL abort_done: got %0d want 0", done_cnt - dc);
      end
      exp_y.delete();
      start = 1'b1;
      step();
      ob = obs_y.size();
      cam_frame(H, -1, -1, -1, 1'b1);
      n_assert++;
      if (obs_y.size() - ob !== W * H || done_cnt - dc !== 1) begin
         n_fail++;
         $display("FAIL abort_restart: pixels %0d done %0d want %0d and 1",
                  obs_y.size() - ob, done_cnt - dc, W * H);
      end else begin
         n_assert++;
         if (pix_mismatch(ob) !== 0) begin
            n_fail++;
            $display("FAIL abort_restart_data: %0d bad pixels want 0", pix_mismatch(ob));
         end
      end
   endtask

   task automatic test_back_to_back();
      int ob, dc;
      exp_y.delete();
      start = 1'b1;
      abort = 1'b1;
      step();
      n_assert++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %b want 0", busy); end
      ob = obs_y.size();
      dc = done_cnt;
      cam_frame(H, -1, -1, -1, 1'b0);
      n_assert++;
      if (obs_y.size() - ob !== 0 || done_cnt - dc !== 0) begin
         n_fail++;
         $display("FAIL start_abort_idle: pixels %0d done %0d want 0 and 0",
                  obs_y.size() - ob, done_cnt - dc);
      end
      start = 1'b1;
      step();
      n_assert++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rearm_busy: got %b want 1", busy); end
      ob = obs_y.size();
      cam_frame(H, -1, 12, -1, 1'b1);
      n_assert++;
      if (done_cnt - dc !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_active: done %0d busy %b want 1 and 0", done_cnt - dc, busy);
      end
      n_assert++;
      if (obs_y.size() - ob !== W * H) begin
         n_fail++;
         $display("FAIL start_in_active_count: got %0d want %0d", obs_y.size() - ob, W * H);
      end
   endtask

   task automatic test_short_frame();
      int ob, wc, dc;
      exp_y.delete();
      start = 1'b1;
      step();
      ob = obs_y.size();
      wc = wv_cnt;
      dc = done_cnt;
      cam_frame(2, -1, -1, -1, 1'b1);
      n_assert++;
      if (wv_cnt - wc !== 0) begin
         n_fail++;
         $display("FAIL short_windows: got %0d want 0", wv_cnt - wc);
      end
      n_assert++;
      if (obs_y.size() - ob !== 2 * W || done_cnt - dc !== 1) begin
         n_fail++;
         $display("FAIL short_pass: pixels %0d done %0d want %0d and 1",
                  obs_y.size() - ob, done_cnt - dc, 2 * W);
      end
      n_assert++;
      if (frame_err !== FE_EXP) begin
         n_fail++;
         $display("FAIL short_lines_err: got %b want %b", frame_err, FE_EXP);
      end
   endtask

   task automatic test_frame_check();
      int ob;
      exp_y.delete();
      start = 1'b1;
      step();
      n_assert++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear_on_start: got %b want 0", frame_err);
      end
      ob = obs_y.size();
      cam_frame(H, 1, -1, -1, 1'b1);
      n_assert++;
      if (obs_y.size() - ob !== W * H - 1) begin
         n_fail++;
         $display("FAIL short_line_count: got %0d want %0d", obs_y.size() - ob, W * H - 1);
      end
      n_assert++;
      if (fe_at_done !== FE_EXP) begin
         n_fail++;
         $display("FAIL err_at_done: got %b want %b", fe_at_done, FE_EXP);
      end
      repeat (5) step();
      n_assert++;
      if (frame_err !== FE_EXP) begin
         n_fail++;
         $display("FAIL err_sticky: got %b want %b", frame_err, FE_EXP);
      end
      start = 1'b1;
      step();
      n_assert++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_cleared: got %b want 0", frame_err);
      end
      abort = 1'b1;
      step();
   endtask

   initial begin
      repeat (3) step();
      rst_n = 1'b1;
      step();
      test_reset();
      test_arm_mid_frame();
      test_window();
      test_abort();
      test_back_to_back();
      test_short_frame();
      test_frame_check();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
